// File: rtl/seg7_scan_driver_if.sv
// Bundle between the display-data producer and the multiplexed seven-segment scanner.
// The master side supplies digit data and controls; the slave side drives the board pins.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 8
);
    logic                  load;
    logic [4*DIGITS-1:0]   hexs;
    logic [DIGITS-1:0]     points;
    logic [DIGITS-1:0]     les;
    logic [DIGITS-1:0]     blink;
    logic [DIGITS-1:0]     an;
    logic [7:0]            seg;
    logic                  frame_done;
    logic                  blink_phase;

    modport master (
        output load, hexs, points, les, blink,
        input  an, seg, frame_done, blink_phase
    );

    modport slave (
        input  load, hexs, points, les, blink,
        output an, seg, frame_done, blink_phase
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode hex display driver with double-buffered digit data,
// per-digit blanking, decimal points and frame-synchronous blinking.
module seg7_scan_driver #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic               clk,
    input  logic               rstn,
    seg7_scan_driver_if.slave  bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(SCAN_DIV - 1);
    localparam logic [FC_W-1:0]  LAST_FC  = FC_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0]    prescaler;
    logic [IDX_W-1:0]    idx;
    logic [FC_W-1:0]     frame_cnt;
    logic                tick;
    logic                wrap;

    logic [4*DIGITS-1:0] shadow_hexs;
    logic [DIGITS-1:0]   shadow_points;
    logic [DIGITS-1:0]   shadow_les;
    logic [DIGITS-1:0]   shadow_blink;
    logic                pending;

    logic [4*DIGITS-1:0] disp_hexs;
    logic [DIGITS-1:0]   disp_points;
    logic [DIGITS-1:0]   disp_les;
    logic [DIGITS-1:0]   disp_blink;

    logic [DIGITS-1:0]   an_q;
    logic [7:0]          seg_q;
    logic                frame_done_q;
    logic                blink_phase_q;

    logic [3:0]          cur_hex;
    logic                cur_point;
    logic                cur_blank;

    function automatic logic [6:0] decode(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    assign tick = (prescaler == LAST_PRE);
    assign wrap = tick && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx <= '0;
        end else if (tick) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt     <= '0;
            blink_phase_q <= 1'b1;
            frame_done_q  <= 1'b0;
        end else begin
            frame_done_q <= wrap;
            if (wrap) begin
                if (frame_cnt == LAST_FC) begin
                    frame_cnt     <= '0;
                    blink_phase_q <= ~blink_phase_q;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // A load coinciding with the frame wrap bypasses the shadow stage so it is
    // shown in the very next frame instead of being parked for a whole frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_hexs   <= '0;
            shadow_points <= '0;
            shadow_les    <= '0;
            shadow_blink  <= '0;
            pending       <= 1'b0;
            disp_hexs     <= '0;
            disp_points   <= '0;
            disp_les      <= '0;
            disp_blink    <= '0;
        end else begin
            if (bus.load) begin
                shadow_hexs   <= bus.hexs;
                shadow_points <= bus.points;
                shadow_les    <= bus.les;
                shadow_blink  <= bus.blink;
            end
            if (wrap && bus.load) begin
                disp_hexs   <= bus.hexs;
                disp_points <= bus.points;
                disp_les    <= bus.les;
                disp_blink  <= bus.blink;
                pending     <= 1'b0;
            end else if (wrap && pending) begin
                disp_hexs   <= shadow_hexs;
                disp_points <= shadow_points;
                disp_les    <= shadow_les;
                disp_blink  <= shadow_blink;
                pending     <= 1'b0;
            end else if (bus.load) begin
                pending <= 1'b1;
            end
        end
    end

    always_comb begin
        cur_hex   = disp_hexs[{idx, 2'b00} +: 4];
        cur_point = disp_points[idx];
        cur_blank = disp_les[idx] | (disp_blink[idx] & ~blink_phase_q);
    end

    // an and seg share one register stage so a digit never shows its neighbour's pattern.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            an_q  <= '1;
            seg_q <= 8'hFF;
        end else begin
            an_q <= ~(DIGITS'(1) << idx);
            if (cur_blank) begin
                seg_q <= 8'hFF;
            end else begin
                seg_q <= {decode(cur_hex), ~cur_point};
            end
        end
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.blink_phase = blink_phase_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed and random loads compared every
// cycle against a model that derives slot, frame and commit times from the clock count.
module tb_seg7_scan_driver;
    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = DIGITS * SCAN_DIV;

    typedef struct {
        int         e;
        logic [15:0] h;
        logic [3:0]  p;
        logic [3:0]  l;
        logic [3:0]  b;
    } load_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   edges  = 0;
    load_t loads[$];

    logic [6:0] seg_tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    seg7_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan_driver #(
        .DIGITS(DIGITS),
        .SCAN_DIV(SCAN_DIV),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Data visible after n edges: the newest load whose frame boundary has been reached.
    function automatic load_t display_at(input int n);
        load_t r;
        r = '{e: 0, h: 16'h0, p: 4'h0, l: 4'h0, b: 4'h0};
        foreach (loads[i]) begin
            if (((loads[i].e + FRAME - 1) / FRAME) * FRAME <= n) r = loads[i];
        end
        return r;
    endfunction

    function automatic logic phase_at(input int n);
        return (((n / FRAME) / BLINK_FRAMES) % 2) == 0;
    endfunction

    task automatic step();
        int         n;
        int         d;
        load_t      cur;
        logic       ph;
        logic       blank;
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        logic [15:0] hw;
        @(posedge clk);
        edges++;
        #1;
        n   = edges - 1;
        d   = (n / SCAN_DIV) % DIGITS;
        cur = display_at(n);
        ph  = phase_at(n);
        hw  = cur.h;
        exp_an    = 4'hF;
        exp_an[d] = 1'b0;
        blank = cur.l[d] | (cur.b[d] & ~ph);
        exp_seg = blank ? 8'hFF : {seg_tbl[hw[d*4 +: 4]], ~cur.p[d]};
        check_output("an", 32'(bus.an), 32'(exp_an));
        check_output("seg", 32'(bus.seg), 32'(exp_seg));
        check_output("frame_done", 32'(bus.frame_done), 32'(edges % FRAME == 0));
        check_output("blink_phase", 32'(bus.blink_phase), 32'(phase_at(edges)));
    endtask

    task automatic apply_stimulus(input logic [15:0] h, input logic [3:0] p,
                                  input logic [3:0] l, input logic [3:0] b);
        bus.load   = 1'b1;
        bus.hexs   = h;
        bus.points = p;
        bus.les    = l;
        bus.blink  = b;
        loads.push_back('{e: edges + 1, h: h, p: p, l: l, b: b});
        step();
        bus.load = 1'b0;
    endtask

    task automatic run_to_wrap();
        while (edges % FRAME != 0) step();
    endtask

    initial begin
        logic [7:0] slot_seg [4];
        logic [3:0] slot_an [4];
        slot_seg = '{8'h71, 8'h9F, 8'h10, 8'h0D};
        slot_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        bus.load = 1'b0;
        bus.hexs = '0;
        bus.points = '0;
        bus.les = '0;
        bus.blink = '0;

        repeat (3) @(posedge clk);
        #1;
        check_output("rst_an", 32'(bus.an), 32'h0000000F);
        check_output("rst_seg", 32'(bus.seg), 32'h000000FF);
        check_output("rst_frame_done", 32'(bus.frame_done), 32'h0);
        check_output("rst_blink_phase", 32'(bus.blink_phase), 32'h1);

        @(negedge clk);
        rstn = 1'b1;
        step();
        check_output("first_an", 32'(bus.an), 32'h0000000E);
        check_output("first_seg", 32'(bus.seg), 32'h00000003);

        $display("[TB] directed load 3A1F");
        repeat (5) step();
        apply_stimulus(16'h3A1F, 4'b0100, 4'b0000, 4'b0000);
        run_to_wrap();
        for (int d = 0; d < DIGITS; d++) begin
            step();
            check_output("slot_an", 32'(bus.an), 32'(slot_an[d]));
            check_output("slot_seg", 32'(bus.seg), 32'(slot_seg[d]));
            repeat (SCAN_DIV - 1) step();
        end

        $display("[TB] blanking and blink");
        apply_stimulus(16'h3A1F, 4'b0100, 4'b0010, 4'b0001);
        repeat (4 * FRAME + 3) step();

        $display("[TB] load on frame wrap");
        while (edges % FRAME != FRAME - 1) step();
        apply_stimulus(16'h8888, 4'b0000, 4'b0000, 4'b0000);
        step();
        check_output("wrap_load_an", 32'(bus.an), 32'h0000000E);
        check_output("wrap_load_seg", 32'(bus.seg), 32'h00000001);
        repeat (FRAME) step();

        $display("[TB] two loads in one frame");
        run_to_wrap();
        repeat (2) step();
        apply_stimulus(16'h1234, 4'b0000, 4'b0000, 4'b0000);
        repeat (3) step();
        apply_stimulus(16'h5678, 4'b0000, 4'b0000, 4'b0000);
        run_to_wrap();
        step();
        check_output("last_load_seg", 32'(bus.seg), 32'h00000001);
        repeat (FRAME) step();

        $display("[TB] random loads");
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 20)) step();
            apply_stimulus(16'($urandom), 4'($urandom), 4'($urandom & $urandom), 4'($urandom));
        end
        repeat (3 * FRAME) step();

        $display("[TB] reset with pending data");
        while (edges % FRAME != 5) step();
        apply_stimulus(16'hBEEF, 4'b1111, 4'b0000, 4'b0000);
        repeat (2) step();
        #2;
        rstn = 1'b0;
        #1;
        check_output("midrst_an", 32'(bus.an), 32'h0000000F);
        check_output("midrst_seg", 32'(bus.seg), 32'h000000FF);
        check_output("midrst_frame_done", 32'(bus.frame_done), 32'h0);
        check_output("midrst_blink_phase", 32'(bus.blink_phase), 32'h1);
        repeat (2) @(negedge clk);
        loads.delete();
        edges = 0;
        rstn = 1'b1;
        step();
        check_output("post_rst_seg", 32'(bus.seg), 32'h00000003);
        repeat (3 * FRAME) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, clocked successor to the static hex-to-8-segment fan-out.
- Takes a packed hex word plus per-digit point, blank and blink controls, and time-multiplexes DIGITS common-anode digits onto one shared segment bus.
- Display data is double-buffered and committed only at frame boundaries, so a load never tears a frame.
- Sits between the ALU/register-display logic and the board's digit-select and segment pins.

Parameters:
DIGITS, 8, number of digits scanned (legal 2..16)
SCAN_DIV, 50000, clocks per digit slot (legal ≥2)
BLINK_FRAMES, 64, full scan frames per blink half-period (legal ≥1)

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
load  input  1  one-cycle strobe; captures hexs/points/les/blink into shadow registers
hexs  input  4*DIGITS  digit i = hexs[4i+3:4i]
points  input  DIGITS  1 = decimal point lit on digit i
les  input  DIGITS  1 = digit i blanked (all segments off)
blink  input  DIGITS  1 = digit i blanked during the blink off-phase
an  output  DIGITS  digit select, active-low, one-cold
seg  output  8  {a,b,c,d,e,f,g,p}, active-low
frame_done  output  1  one-cycle pulse at each frame wrap
blink_phase  output  1  1 = visible phase

Behaviour:
- Reset (rstn=0, async):
  - Outputs: an = all 1, seg = 8'hFF, frame_done = 0, blink_phase = 1.
  - Internal: prescaler = 0, idx = 0, frame counter = 0, shadow regs = 0, display regs = 0, pending = 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - tick = (prescaler == SCAN_DIV-1).
- Digit index idx:
  - On tick: idx <= (idx == DIGITS-1) ? 0 : idx+1.
- Frame wrap: tick with idx == DIGITS-1. On the same edge:
  - frame_done <= 1 for exactly one cycle; 0 otherwise.
  - If pending, the display regs take the shadow regs and pending clears.
  - Frame counter increments. At BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- load:
  - On any edge with load=1, the shadow regs take the inputs and pending <= 1.
  - load on the same edge as a frame wrap: the display regs take the new input values directly and pending ends 0.
  - A second load before the wrap overwrites the shadow regs (last one wins).
- Output register (every clock, 1-cycle latency from idx / display regs):
  - an <= ~(1 << idx).
  - Digit blanked when: les[idx] | (blink[idx] & ~blink_phase).
  - Blanked digit: seg <= 8'hFF.
  - Otherwise: seg[7:1] <= decode(hex[idx]) and seg[0] <= ~points[idx].
  - Blanking applies to the point as well.
- Decode, active-low a..g:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
- an is always exactly one-cold after the first post-reset clock. No ghosting cycle: an and seg change on the same edge.
- Reset asserted mid-frame: all state returns to reset values immediately. Pending data is discarded.

Test Plan (DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2):
- Reset, hold rstn=0 → an=4'hF, seg=8'hFF, frame_done=0, blink_phase=1. Release → first clock an=4'b1110, seg=8'h03 (digit 0, value 0, point off).
- Pulse load with hexs=16'h3A1F, points=4'b0100, les=0, blink=0 → display unchanged until first frame_done; then, per slot:
  - digit0: an=1110, seg=8'h71.
  - digit1: an=1101, seg=8'h9F.
  - digit2: an=1011, seg=8'h10.
  - digit3: an=0111, seg=8'h0D.
- Slot timing → an advances every 4 clocks; frame_done pulses once every 16 clocks for exactly 1 cycle; blink_phase toggles every 32 clocks.
- les=4'b0010 after load → digit1 slot shows seg=8'hFF. blink=4'b0001 → digit0 shows 8'hFF only while blink_phase=0.
- load asserted exactly on the frame-wrap edge with hexs=16'h8888 → next slot shows seg=8'h01 with no extra frame delay. Two loads in one frame → only the second value is displayed.
- Assert rstn=0 while pending=1 mid-frame → outputs immediately an=4'hF, seg=8'hFF. After release the display shows zeros; the pending data is never shown.
